// File: rtl/quad_encoder_if.sv
// Encoder phase inputs, position control and tick/position outputs of quad_encoder.
interface quad_encoder_if #(
   parameter int unsigned WIDTH = 3
);
   logic             s1;
   logic             s2;
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic [WIDTH-1:0] value;
   logic             r_tick;
   logic             l_tick;
   logic             err;

   modport master (
      output s1, s2, clear, load, load_value,
      input  value, r_tick, l_tick, err
   );

   modport slave (
      input  s1, s2, clear, load, load_value,
      output value, r_tick, l_tick, err
   );
endinterface

// File: rtl/quad_encoder.sv
// Quadrature rotary-encoder decoder: phase synchroniser, glitch filter, Gray decode,
// detent accumulator and a wrap/saturate position register with clear and load.
module quad_encoder #(
   parameter int unsigned WIDTH            = 3,
   parameter int unsigned FILT_CYCLES      = 4,
   parameter int unsigned STEPS_PER_DETENT = 4,
   parameter int unsigned WRAP             = 1,
   parameter int unsigned MAX_VAL          = (1 << WIDTH) - 1
) (
   input logic           clk,
   input logic           rst,
   quad_encoder_if.slave bus
);
   localparam int unsigned      CW       = $clog2(FILT_CYCLES) + 1;
   localparam int unsigned      AW       = $clog2(STEPS_PER_DETENT) + 2;
   localparam logic [CW-1:0]    CNT_LAST = CW'(FILT_CYCLES - 1);
   localparam logic [AW-1:0]    ACC_TOP  = AW'(STEPS_PER_DETENT - 1);
   localparam logic [AW-1:0]    ACC_BOT  = AW'(0) - ACC_TOP;
   localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_VAL);

   // Phase vectors are {A, B}.
   logic [1:0]       sync1_q, sync1_d;
   logic [1:0]       sync2_q, sync2_d;
   logic [1:0]       filt_q, filt_d;
   logic [1:0]       prev_q, prev_d;
   logic [CW-1:0]    cnt_a_q, cnt_a_d;
   logic [CW-1:0]    cnt_b_q, cnt_b_d;
   logic [AW-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic             r_q, r_d;
   logic             l_q, l_d;
   logic             err_q, err_d;
   logic [1:0]       step;

   // Position of a phase state along the clockwise cycle 11 -> 01 -> 00 -> 10.
   function automatic logic [1:0] gray_idx(input logic [1:0] ab);
      logic [1:0] idx;
      case (ab)
         2'b11:   idx = 2'd0;
         2'b01:   idx = 2'd1;
         2'b00:   idx = 2'd2;
         default: idx = 2'd3;
      endcase
      return idx;
   endfunction

   // Returns {filtered, counter}: filtered follows synced after FILT_CYCLES differing edges.
   function automatic logic [CW:0] filt_next(input logic synced, input logic filt,
                                             input logic [CW-1:0] cnt);
      logic [CW:0] res;
      res = {filt, CW'(0)};
      if (synced != filt) begin
         if (cnt == CNT_LAST) res = {synced, CW'(0)};
         else                 res = {filt, cnt + CW'(1)};
      end
      return res;
   endfunction

   always_comb begin
      sync1_d = {bus.s1, bus.s2};
      sync2_d = sync1_q;
      {filt_d[1], cnt_a_d} = filt_next(sync2_q[1], filt_q[1], cnt_a_q);
      {filt_d[0], cnt_b_d} = filt_next(sync2_q[0], filt_q[0], cnt_b_q);
      prev_d  = filt_q;
      acc_d   = acc_q;
      value_d = value_q;
      r_d     = 1'b0;
      l_d     = 1'b0;
      err_d   = 1'b0;
      step    = gray_idx(filt_q) - gray_idx(prev_q);

      // Distance 1 is a clockwise step, 3 counter-clockwise, 2 a skipped state.
      case (step)
         2'd1: begin
            if (acc_q == ACC_TOP) begin
               r_d   = 1'b1;
               acc_d = '0;
            end else begin
               acc_d = acc_q + AW'(1);
            end
         end
         2'd3: begin
            if (acc_q == ACC_BOT) begin
               l_d   = 1'b1;
               acc_d = '0;
            end else begin
               acc_d = acc_q - AW'(1);
            end
         end
         2'd2: begin
            err_d = 1'b1;
            acc_d = '0;
         end
         default: ;
      endcase

      if (r_d) begin
         value_d = (WRAP == 0 && value_q >= MAX_V) ? value_q : value_q + WIDTH'(1);
      end else if (l_d) begin
         value_d = (WRAP == 0 && value_q == '0) ? value_q : value_q - WIDTH'(1);
      end

      if (bus.clear) begin
         value_d = '0;
         acc_d   = '0;
         r_d     = 1'b0;
         l_d     = 1'b0;
      end else if (bus.load) begin
         value_d = (WRAP == 0 && bus.load_value > MAX_V) ? MAX_V : bus.load_value;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
         filt_q  <= 2'b11;
         prev_q  <= 2'b11;
         cnt_a_q <= '0;
         cnt_b_q <= '0;
         acc_q   <= '0;
         value_q <= '0;
         r_q     <= 1'b0;
         l_q     <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         filt_q  <= filt_d;
         prev_q  <= prev_d;
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
         acc_q   <= acc_d;
         value_q <= value_d;
         r_q     <= r_d;
         l_q     <= l_d;
         err_q   <= err_d;
      end
   end

   assign bus.value  = value_q;
   assign bus.r_tick = r_q;
   assign bus.l_tick = l_q;
   assign bus.err    = err_q;
endmodule
